mem_port_arbiter: RTL and testbench

Shares the core's single memory port between the instruction-fetch requester and the load/store requester. It sits between the core and the unified memory. It accepts one request at a time through valid/ready handshakes and presents it to memory on a registered request channel. It then routes the single memory response back to whichever requester owns the transaction. Load/store wins by default; a streak counter prevents instruction fetch from starving.

---
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and load/store, one transaction outstanding.
// Request registered one cycle after grant; mem_req_ready stalls hold it, response passes through same cycle.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic                ls_req_we,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_be,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_we,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_be,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  output logic                busy
);
  localparam int BE_W = DATA_W / 8;
  localparam int SW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_RESP} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;

  state_t        r_state;
  state_t        w_next_state;
  owner_t        r_owner;
  req_t          r_req;
  logic [SW-1:0] r_streak;
  logic          w_idle;
  logic          w_grant_if;
  logic          w_grant_ls;
  logic          w_rsp_fire;

  // Grants and response pulses are suppressed while reset is asserted so nothing is accepted and lost.
  assign w_idle     = (r_state == ST_IDLE) && !rst;
  assign w_grant_ls = w_idle && ls_req_valid && (!if_req_valid || (r_streak != LIMIT));
  assign w_grant_if = w_idle && if_req_valid && !w_grant_ls;
  assign w_rsp_fire = (r_state == ST_WAIT_RESP) && mem_rsp_valid && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:      if (w_grant_if || w_grant_ls) w_next_state = ST_ISSUE;
      ST_ISSUE:     if (mem_req_ready) w_next_state = ST_WAIT_RESP;
      ST_WAIT_RESP: if (mem_rsp_valid) w_next_state = ST_IDLE;
      default:      w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    if_req_ready  = w_grant_if;
    ls_req_ready  = w_grant_ls;
    mem_req_valid = (r_state == ST_ISSUE);
    busy          = (r_state != ST_IDLE);
    if_rsp_valid  = w_rsp_fire && (r_owner == OWN_IF);
    ls_rsp_valid  = w_rsp_fire && (r_owner == OWN_LS);
    if_rsp_data   = mem_rsp_data;
    ls_rsp_data   = mem_rsp_data;
  end

  assign mem_req_addr  = r_req.addr;
  assign mem_req_we    = r_req.we;
  assign mem_req_wdata = r_req.wdata;
  assign mem_req_be    = r_req.be;

  // Streak counts LS grants taken while fetch was waiting; it resets whenever fetch is not being passed over.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner  <= OWN_IF;
      r_req    <= '0;
      r_streak <= '0;
    end else if (w_grant_ls) begin
      r_owner  <= OWN_LS;
      r_req    <= '{addr: ls_req_addr, we: ls_req_we, wdata: ls_req_wdata, be: ls_req_be};
      if (!if_req_valid) begin
        r_streak <= '0;
      end else if (r_streak != LIMIT) begin
        r_streak <= r_streak + SW'(1);
      end
    end else if (w_grant_if) begin
      r_owner  <= OWN_IF;
      r_req    <= '{addr: if_req_addr, we: 1'b0, wdata: {DATA_W{1'b0}}, be: {BE_W{1'b1}}};
      r_streak <= '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_req_addr, if_rsp_data;
  logic        ls_req_valid, ls_req_ready, ls_req_we, ls_rsp_valid;
  logic [31:0] ls_req_addr, ls_req_wdata, ls_rsp_data;
  logic [3:0]  ls_req_be;
  logic        mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid, busy;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
  logic [3:0]  mem_req_be;

  int errs   = 0;
  int checks = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_req_we(ls_req_we), .ls_req_wdata(ls_req_wdata), .ls_req_be(ls_req_be),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    if_req_valid = 0; if_req_addr = 0;
    ls_req_valid = 0; ls_req_addr = 0; ls_req_we = 0; ls_req_wdata = 0; ls_req_be = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
  endtask

  // Ends at the negedge of the first cycle after reset is released.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, mem_req_valid, busy} !== 6'b0) begin
      errs++; $display("FAIL reset_ctrl got=%b exp=000000", {if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, mem_req_valid, busy});
    end
    checks++; if ({mem_req_addr, mem_req_we, mem_req_wdata, mem_req_be} !== 69'd0) begin
      errs++; $display("FAIL reset_fields got=%h exp=0", {mem_req_addr, mem_req_we, mem_req_wdata, mem_req_be});
    end
  endtask

  task automatic test_lone_fetch();
    do_reset();
    @(posedge clk); #1; if_req_valid = 1; if_req_addr = 32'h10; mem_req_ready = 1;
    @(negedge clk);
    checks++; if ({if_req_ready, ls_req_ready} !== 2'b10) begin errs++; $display("FAIL fetch_grant got=%b exp=10", {if_req_ready, ls_req_ready}); end
    @(posedge clk); #1; if_req_valid = 0; if_req_addr = 32'hFFFF_0000;
    @(negedge clk);
    checks++; if ({mem_req_valid, mem_req_addr, mem_req_we, mem_req_be} !== {1'b1, 32'h10, 1'b0, 4'hF}) begin
      errs++; $display("FAIL fetch_req got=%b/%h/%b/%h exp=1/00000010/0/f", mem_req_valid, mem_req_addr, mem_req_we, mem_req_be);
    end
    @(posedge clk); #1; mem_rsp_valid = 1; mem_rsp_data = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if ({if_rsp_valid, ls_rsp_valid, if_rsp_data} !== {2'b10, 32'hDEADBEEF}) begin
      errs++; $display("FAIL fetch_rsp got=%b%b/%h exp=10/deadbeef", if_rsp_valid, ls_rsp_valid, if_rsp_data);
    end
    @(posedge clk); #1; mem_rsp_valid = 0;
    @(negedge clk);
    checks++; if ({busy, if_rsp_valid} !== 2'b00) begin errs++; $display("FAIL fetch_done got=%b exp=00", {busy, if_rsp_valid}); end
  endtask

  task automatic test_store();
    do_reset();
    @(posedge clk); #1;
    ls_req_valid = 1; ls_req_addr = 32'h20; ls_req_we = 1; ls_req_wdata = 32'h12345678; ls_req_be = 4'h3; mem_req_ready = 1;
    @(negedge clk);
    checks++; if ({if_req_ready, ls_req_ready, busy} !== 3'b010) begin errs++; $display("FAIL store_grant got=%b exp=010", {if_req_ready, ls_req_ready, busy}); end
    @(posedge clk); #1; ls_req_valid = 0; ls_req_addr = 32'h0; ls_req_wdata = 32'h0;
    @(negedge clk);
    checks++; if ({mem_req_valid, busy, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_be} !== {2'b11, 32'h20, 1'b1, 32'h12345678, 4'h3}) begin
      errs++; $display("FAIL store_req got=%b%b/%h/%b/%h/%h", mem_req_valid, busy, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_be);
    end
    @(posedge clk); #1; mem_rsp_valid = 1; mem_rsp_data = 32'h5A5A5A5A;
    @(negedge clk);
    checks++; if ({ls_rsp_valid, if_rsp_valid, busy} !== 3'b101) begin errs++; $display("FAIL store_ack got=%b exp=101", {ls_rsp_valid, if_rsp_valid, busy}); end
    @(posedge clk); #1; mem_rsp_valid = 0;
    @(negedge clk);
    checks++; if ({busy, ls_rsp_valid} !== 2'b00) begin errs++; $display("FAIL store_done got=%b exp=00", {busy, ls_rsp_valid}); end
  endtask

  task automatic test_starvation();
    int grants = 0;
    bit prev_if = 0;
    do_reset();
    @(posedge clk); #1;
    if_req_valid = 1; ls_req_valid = 1; mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_data = 32'h1;
    @(negedge clk);
    for (int c = 0; c < 60 && grants < 10; c++) begin
      if (c > 0) begin @(posedge clk); #1; @(negedge clk); end
      if (prev_if) begin
        checks++; if (dut.r_streak !== 3'd0) begin errs++; $display("FAIL starve_streak_after got=%0d exp=0", dut.r_streak); end
        prev_if = 0;
      end
      if (if_req_ready || ls_req_ready) begin
        // Every fifth grant goes to fetch once LS has been chosen LIM times in a row.
        bit exp_if = ((grants % (LIM + 1)) == LIM);
        checks++; if ({if_req_ready, ls_req_ready} !== {exp_if, !exp_if}) begin
          errs++; $display("FAIL starve_order grant=%0d got=%b exp=%b", grants, {if_req_ready, ls_req_ready}, {exp_if, !exp_if});
        end
        if (exp_if) begin
          checks++; if (dut.r_streak !== 3'(LIM)) begin errs++; $display("FAIL starve_streak_at got=%0d exp=%0d", dut.r_streak, LIM); end
          prev_if = 1;
        end
        grants++;
      end
    end
    checks++; if (grants != 10) begin errs++; $display("FAIL starve_count got=%0d exp=10", grants); end
    @(posedge clk); #1; clear_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    @(posedge clk); #1;
    ls_req_valid = 1; ls_req_addr = 32'h40; ls_req_we = 0; ls_req_wdata = 32'h77; ls_req_be = 4'hF; mem_req_ready = 0;
    @(negedge clk);
    checks++; if (ls_req_ready !== 1'b1) begin errs++; $display("FAIL bp_grant got=%b exp=1", ls_req_ready); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1; if_req_valid = 1; ls_req_addr = $urandom; ls_req_wdata = $urandom;
      @(negedge clk);
      checks++; if ({mem_req_valid, if_req_ready, ls_req_ready, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_be} !== {3'b100, 32'h40, 1'b0, 32'h77, 4'hF}) begin
        errs++; $display("FAIL bp_hold cyc=%0d got=%b%b%b/%h/%b/%h/%h", c, mem_req_valid, if_req_ready, ls_req_ready, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_be);
      end
    end
    @(posedge clk); #1; if_req_valid = 0; ls_req_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    checks++; if (mem_req_valid !== 1'b1) begin errs++; $display("FAIL bp_accept got=%b exp=1", mem_req_valid); end
    @(posedge clk); #1; mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'hCAFEF00D;
    @(negedge clk);
    checks++; if ({ls_rsp_valid, if_rsp_valid, ls_rsp_data} !== {2'b10, 32'hCAFEF00D}) begin
      errs++; $display("FAIL bp_rsp got=%b%b/%h exp=10/cafef00d", ls_rsp_valid, if_rsp_valid, ls_rsp_data);
    end
    @(posedge clk); #1; mem_rsp_valid = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL bp_done got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(posedge clk); #1; if_req_valid = 1; if_req_addr = 32'h80; mem_req_ready = 1;
    @(posedge clk); #1; if_req_valid = 0;
    @(posedge clk); #1; rst = 1; mem_req_ready = 0;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    checks++; if ({if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, mem_req_valid, busy, mem_req_addr, mem_req_be} !== 42'd0) begin
      errs++; $display("FAIL rstmid_outputs got=%b%b%b%b%b%b/%h/%h exp=0", if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, mem_req_valid, busy, mem_req_addr, mem_req_be);
    end
    @(posedge clk); #1; mem_rsp_valid = 1; mem_rsp_data = 32'hBAD0BAD0;
    @(negedge clk);
    checks++; if ({if_rsp_valid, ls_rsp_valid, busy} !== 3'b000) begin errs++; $display("FAIL rstmid_late_rsp got=%b exp=000", {if_rsp_valid, ls_rsp_valid, busy}); end
    @(posedge clk); #1; mem_rsp_valid = 0; ls_req_valid = 1; ls_req_addr = 32'h90; ls_req_we = 0; ls_req_be = 4'hF; mem_req_ready = 1;
    @(negedge clk);
    checks++; if (ls_req_ready !== 1'b1) begin errs++; $display("FAIL rstmid_regrant got=%b exp=1", ls_req_ready); end
    @(posedge clk); #1; ls_req_valid = 0;
    @(negedge clk);
    checks++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h90}) begin errs++; $display("FAIL rstmid_req got=%b/%h exp=1/00000090", mem_req_valid, mem_req_addr); end
    @(posedge clk); #1; mem_rsp_valid = 1; mem_rsp_data = 32'h600D600D;
    @(negedge clk);
    checks++; if ({ls_rsp_valid, if_rsp_valid, ls_rsp_data} !== {2'b10, 32'h600D600D}) begin
      errs++; $display("FAIL rstmid_rsp got=%b%b/%h exp=10/600d600d", ls_rsp_valid, if_rsp_valid, ls_rsp_data);
    end
    @(posedge clk); #1; clear_inputs();
  endtask

  task automatic test_spurious();
    do_reset();
    @(posedge clk); #1; mem_rsp_valid = 1; mem_rsp_data = 32'h11112222;
    @(negedge clk);
    checks++; if ({if_rsp_valid, ls_rsp_valid, busy, mem_req_valid} !== 4'b0000) begin
      errs++; $display("FAIL spurious_pulse got=%b exp=0000", {if_rsp_valid, ls_rsp_valid, busy, mem_req_valid});
    end
    @(posedge clk); #1; mem_rsp_valid = 0;
    @(negedge clk);
    checks++; if ({busy, mem_req_valid} !== 2'b00) begin errs++; $display("FAIL spurious_state got=%b exp=00", {busy, mem_req_valid}); end
  endtask

  // Randomized traffic checked against a transaction-level model: pending requests, one outstanding txn, streak count.
  task automatic test_random();
    int          streak = 0;
    int          rwait = 0;
    bit          if_pend = 0, ls_pend = 0, outst = 0, acc = 0, own_ls = 0, rsp_now, win_ls, win_if;
    logic [31:0] if_a = 0, ls_a = 0, ls_wd = 0, e_addr = 0, e_wd = 0;
    logic        ls_w = 0, e_we = 0;
    logic [3:0]  ls_b = 0, e_be = 0;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(posedge clk); #1;
      if (!if_pend && $urandom_range(0, 1) == 1) begin if_pend = 1; if_a = $urandom; end
      if (!ls_pend && $urandom_range(0, 1) == 1) begin
        ls_pend = 1; ls_a = $urandom; ls_w = 1'($urandom_range(0, 1)); ls_wd = $urandom; ls_b = 4'($urandom);
      end
      if_req_valid = if_pend; if_req_addr = if_pend ? if_a : $urandom;
      ls_req_valid = ls_pend; ls_req_addr = ls_pend ? ls_a : $urandom;
      ls_req_we = ls_w; ls_req_wdata = ls_pend ? ls_wd : $urandom; ls_req_be = ls_b;
      mem_req_ready = ($urandom_range(0, 9) < 6);
      mem_rsp_data = $urandom;
      if (outst && acc) begin
        rsp_now = (rwait == 0);
        if (rwait > 0) rwait--;
      end else begin
        rsp_now = ($urandom_range(0, 9) == 0);
      end
      mem_rsp_valid = rsp_now;
      @(negedge clk);
      if (!outst) begin
        win_ls = ls_pend && (!if_pend || streak != LIM);
        win_if = if_pend && !win_ls;
        checks++; if ({if_req_ready, ls_req_ready, mem_req_valid, busy, if_rsp_valid, ls_rsp_valid} !== {win_if, win_ls, 4'b0000}) begin
          errs++; $display("FAIL rnd_idle cyc=%0d got=%b exp=%b0000", cyc, {if_req_ready, ls_req_ready, mem_req_valid, busy, if_rsp_valid, ls_rsp_valid}, {win_if, win_ls});
        end
        if (win_ls) begin
          streak = if_pend ? ((streak < LIM) ? streak + 1 : LIM) : 0;
          e_addr = ls_a; e_we = ls_w; e_wd = ls_wd; e_be = ls_b; own_ls = 1; ls_pend = 0; outst = 1; acc = 0;
        end else if (win_if) begin
          streak = 0;
          e_addr = if_a; e_we = 0; e_be = 4'hF; own_ls = 0; if_pend = 0; outst = 1; acc = 0;
        end
      end else if (!acc) begin
        checks++; if ({mem_req_valid, busy, if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, mem_req_addr, mem_req_we, mem_req_be} !== {6'b110000, e_addr, e_we, e_be}) begin
          errs++; $display("FAIL rnd_issue cyc=%0d got=%b/%h/%b/%h exp=110000/%h/%b/%h", cyc,
            {mem_req_valid, busy, if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid}, mem_req_addr, mem_req_we, mem_req_be, e_addr, e_we, e_be);
        end
        if (own_ls && e_we) begin
          checks++; if (mem_req_wdata !== e_wd) begin errs++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, mem_req_wdata, e_wd); end
        end
        if (mem_req_ready) begin acc = 1; rwait = $urandom_range(0, 3); end
      end else begin
        checks++; if ({mem_req_valid, busy, if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid} !== {4'b0100, rsp_now && !own_ls, rsp_now && own_ls}) begin
          errs++; $display("FAIL rnd_wait cyc=%0d got=%b exp=0100%b%b", cyc, {mem_req_valid, busy, if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid}, rsp_now && !own_ls, rsp_now && own_ls);
        end
        if (rsp_now) begin
          checks++; if ((own_ls ? ls_rsp_data : if_rsp_data) !== mem_rsp_data) begin
            errs++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, own_ls ? ls_rsp_data : if_rsp_data, mem_rsp_data);
          end
          outst = 0;
        end
      end
    end
    @(posedge clk); #1; clear_inputs();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_lone_fetch();
    test_store();
    test_starvation();
    test_backpressure();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
